eth_tx_arb: RTL and testbench

Parametrised GMII transmit arbiter. It merges CH_NUM independent frame sources (ARP, UDP, and later ICMP or a second UDP stream) onto one GMII transmit port in the gmii_tx_clk domain. Arbitration is frame-atomic: a fixed-priority channel is served first, round-robin applies among the rest, and a programmable inter-frame gap follows every frame. It replaces the two-source ARP/UDP switch in the Ethernet top level and sits between the protocol engines and gmii_to_rgmii.

---
 rtl/eth_pkg.sv | 24 ++
 rtl/eth_rr_pick.sv | 34 +++
 rtl/eth_tx_arb.sv | 148 ++++++++++++++
 tb/tb_eth_tx_arb.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants: channel indices, GMII defaults, arbiter FSM encodings.
package eth_pkg;

  // Fixed channel assignment on the transmit arbiter
  localparam int unsigned CH_ARP  = 0;
  localparam int unsigned CH_UDP  = 1;
  localparam int unsigned CH_ICMP = 2;

  // GMII defaults
  localparam int unsigned GMII_DW     = 8;
  localparam int unsigned IFG_DEFAULT = 12;

  // Transmit arbiter FSM encodings (kept as plain constants for legacy users)
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_XMIT     = 2'd2;
  localparam logic [1:0] ST_IFG      = 2'd3;

  // Index arithmetic modulo n, used for round-robin scanning
  function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational winner selection: fixed-priority channel first, then
// round-robin among the others starting at ptr.
module eth_rr_pick
  import eth_pkg::*;
#(
  parameter int unsigned CH_NUM  = 3,
  parameter int unsigned PRIO_CH = CH_ARP,
  parameter int unsigned PW      = $clog2(CH_NUM)
) (
  input  logic [CH_NUM-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [CH_NUM-1:0] win,
  output logic              valid
);

  // One-hot winner: priority channel overrides, else first requester upward from ptr
  always_comb begin
    logic [PW-1:0] j;
    win   = '0;
    j     = '0;
    valid = |req;
    if (req[PRIO_CH]) begin
      win[PRIO_CH] = 1'b1;
    end else begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        j = PW'(wrap_add(32'(ptr), i, CH_NUM));
        if ((win == '0) && (j != PW'(PRIO_CH)) && req[j]) begin
          win[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/eth_tx_arb.sv
// GMII transmit arbiter: frame-atomic merge of CH_NUM sources onto one
// GMII port with priority/round-robin selection, start timeout and IFG.
module eth_tx_arb
  import eth_pkg::*;
#(
  parameter int unsigned CH_NUM     = 3,
  parameter int unsigned DW         = GMII_DW,
  parameter int unsigned PRIO_CH    = CH_ARP,
  parameter int unsigned IFG_CYCLES = IFG_DEFAULT,
  parameter int unsigned START_TO   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH_NUM-1:0]    ch_req,
  output logic [CH_NUM-1:0]    ch_gnt,
  input  logic [CH_NUM-1:0]    ch_tx_en,
  input  logic [CH_NUM*DW-1:0] ch_txd,
  output logic                 gmii_tx_en,
  output logic [DW-1:0]        gmii_txd,
  output logic                 busy,
  output logic                 to_err
);

  localparam int unsigned PW = $clog2(CH_NUM);
  localparam int unsigned TW = (START_TO > 1) ? $clog2(START_TO) : 1;
  localparam int unsigned IW = $clog2(IFG_CYCLES + 1);

  logic [1:0]        state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gnt_idx;
  logic [TW-1:0]     to_cnt;
  logic [IW-1:0]     ifg_cnt;
  logic [CH_NUM-1:0] pick_win;
  logic              pick_valid;
  logic [PW-1:0]     pick_idx;
  logic [PW-1:0]     next_ptr;
  logic              sel_tx_en;
  logic              sel_req;
  logic [DW-1:0]     sel_txd;

  eth_rr_pick #(
    .CH_NUM (CH_NUM),
    .PRIO_CH(PRIO_CH),
    .PW     (PW)
  ) u_pick (
    .req  (ch_req),
    .ptr  (rr_ptr),
    .win  (pick_win),
    .valid(pick_valid)
  );

  // Encode the picker's one-hot winner into an index
  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (pick_win[i]) pick_idx = PW'(i);
    end
  end

  // Lanes of the granted channel; all other channels are ignored
  always_comb begin
    sel_tx_en = 1'b0;
    sel_req   = 1'b0;
    sel_txd   = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (gnt_idx == PW'(i)) begin
        sel_tx_en = ch_tx_en[i];
        sel_req   = ch_req[i];
        sel_txd   = ch_txd[i*DW +: DW];
      end
    end
  end

  assign next_ptr = PW'(wrap_add(32'(gnt_idx), 1, CH_NUM));
  assign busy     = (state != ST_IDLE);

  // Arbitration FSM with start-timeout and inter-frame-gap counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      ch_gnt  <= '0;
      gnt_idx <= '0;
      rr_ptr  <= '0;
      to_cnt  <= '0;
      ifg_cnt <= '0;
      to_err  <= 1'b0;
    end else begin
      to_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            ch_gnt  <= pick_win;
            gnt_idx <= pick_idx;
            to_cnt  <= '0;
            state   <= ST_WAIT_SOF;
          end
        end
        ST_WAIT_SOF: begin
          if (sel_tx_en) begin
            state <= ST_XMIT;
          end else if (!sel_req) begin
            ch_gnt <= '0;
            state  <= ST_IDLE;
          end else if (to_cnt == TW'(START_TO - 1)) begin
            ch_gnt <= '0;
            to_err <= 1'b1;
            state  <= ST_IDLE;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_XMIT: begin
          if (!sel_tx_en) begin
            ch_gnt  <= '0;
            ifg_cnt <= IW'(IFG_CYCLES);
            state   <= ST_IFG;
            if (gnt_idx != PW'(PRIO_CH)) rr_ptr <= next_ptr;
          end
        end
        ST_IFG: begin
          // ifg_cnt counts down so the last gap cycle hands over to IDLE
          if (ifg_cnt <= IW'(1)) begin
            ifg_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            ifg_cnt <= ifg_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered GMII mux; idle outputs are forced to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gmii_tx_en <= 1'b0;
      gmii_txd   <= '0;
    end else if ((ch_gnt != '0) && (state != ST_IFG)) begin
      gmii_tx_en <= sel_tx_en;
      gmii_txd   <= sel_tx_en ? sel_txd : '0;
    end else begin
      gmii_tx_en <= 1'b0;
      gmii_txd   <= '0;
    end
  end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Randomised scoreboard bench for eth_tx_arb with a priority/round-robin reference model.
module tb_eth_tx_arb;
  import eth_pkg::*;

  localparam int N    = 3;
  localparam int DW   = 8;
  localparam int PRIO = CH_ARP;
  localparam int IFG  = 12;
  localparam int STO  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ch_req;
  logic [N-1:0]    ch_gnt;
  logic [N-1:0]    ch_tx_en;
  logic [N*DW-1:0] ch_txd;
  logic            gmii_tx_en;
  logic [DW-1:0]   gmii_txd;
  logic            busy;
  logic            to_err;

  always #5 clk = ~clk;

  eth_tx_arb #(
    .CH_NUM    (N),
    .DW        (DW),
    .PRIO_CH   (PRIO),
    .IFG_CYCLES(IFG),
    .START_TO  (STO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_req    (ch_req),
    .ch_gnt    (ch_gnt),
    .ch_tx_en  (ch_tx_en),
    .ch_txd    (ch_txd),
    .gmii_tx_en(gmii_tx_en),
    .gmii_txd  (gmii_txd),
    .busy      (busy),
    .to_err    (to_err)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  int         gnt_log[$];
  bit         mon_en = 1'b0;

  function automatic void chk(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Reference winner: priority channel, else smallest forward distance from rr
  function automatic int model_pick(logic [N-1:0] req, int rr);
    int best  = -1;
    int bestd = N + 1;
    if (req[PRIO]) return PRIO;
    for (int c = 0; c < N; c++) begin
      if (req[c] && c != PRIO) begin
        int d = (c - rr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = c;
        end
      end
    end
    return best;
  endfunction

  // Monitor / scoreboard, sampling 1 time unit after each rising edge
  int         cyc = 0, rr_m = 0, g_cyc = 0, g_ch = 0, end_cyc = 0;
  bit         have_end = 1'b0, seen = 1'b0;
  logic [N-1:0] prev_gnt = '0;
  logic       prev_busy = 1'b0;
  int         w;
  logic [7:0] e;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!mon_en || rst) begin
      rr_m     = 0;
      have_end = 1'b0;
      seen     = 1'b0;
    end else begin
      if (prev_gnt == '0 && ch_gnt != '0) begin
        w = model_pick(ch_req, rr_m);
        chk("grant_onehot", longint'($countones(ch_gnt)), 1);
        chk("grant_winner", longint'(ch_gnt), (w < 0) ? 0 : longint'(1 << w));
        g_cyc = cyc;
        g_ch  = w;
        seen  = 1'b0;
        gnt_log.push_back(w);
        if (have_end) chk("ifg_gap", longint'(cyc - end_cyc >= IFG + 1), 1);
      end
      if (!prev_busy) chk("idle_grant", longint'(ch_gnt != '0), longint'(ch_req != '0));
      if (gmii_tx_en) begin
        chk("byte_expected", longint'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("gmii_txd", longint'(gmii_txd), longint'(e));
        end
        seen = 1'b1;
      end
      if (prev_gnt != '0 && ch_gnt == '0) begin
        if (seen) begin
          chk("eof_en_low", longint'(gmii_tx_en), 0);
          chk("eof_drained", longint'(exp_q.size()), 0);
          chk("eof_no_to_err", longint'(to_err), 0);
          if (g_ch != PRIO) rr_m = (g_ch + 1) % N;
          end_cyc  = cyc;
          have_end = 1'b1;
        end else begin
          chk("to_err_pulse", longint'(to_err), 1);
          chk("to_latency", longint'(cyc - g_cyc), STO);
        end
      end else if (to_err) begin
        chk("to_err_spurious", longint'(to_err), 0);
      end
      if (have_end && cyc > end_cyc && cyc < end_cyc + IFG) begin
        chk("ifg_busy", longint'(busy), 1);
        chk("ifg_quiet", longint'(gmii_tx_en), 0);
      end
      if (have_end && cyc == end_cyc + IFG) chk("ifg_release", longint'(busy), 0);
    end
    prev_gnt  = ch_gnt;
    prev_busy = busy;
  end

  // Per-channel source state
  int fl[N], len[N], pos[N], dly[N];
  bit snd[N], nostart[N], wasg[N];

  function automatic logic [7:0] rnd_byte();
    logic [7:0] b = 8'($urandom_range(0, 255));
    if (b == 8'hAA) b = 8'h5A;
    return b;
  endfunction

  task automatic queue_frames(int c, int frames, int l, int d);
    fl[c]     = frames;
    len[c]    = l;
    dly[c]    = d;
    pos[c]    = 0;
    snd[c]    = 1'b0;
    ch_req[c] = 1'b1;
  endtask

  // One negedge of source behaviour: granted channel sends its frame, others emit 8'hAA noise
  task automatic drive_cycle();
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      if (ch_gnt[c]) begin
        wasg[c] = 1'b1;
        if (nostart[c]) begin
          ch_tx_en[c] = 1'b0;
          ch_txd[c*DW +: DW] = '0;
        end else if (!snd[c] && dly[c] > 0) begin
          dly[c]--;
          ch_tx_en[c] = 1'b0;
          ch_txd[c*DW +: DW] = '0;
        end else begin
          snd[c] = 1'b1;
          if (pos[c] < len[c]) begin
            logic [7:0] b = rnd_byte();
            ch_tx_en[c] = 1'b1;
            ch_txd[c*DW +: DW] = b;
            exp_q.push_back(b);
            pos[c]++;
          end else begin
            ch_tx_en[c] = 1'b0;
            ch_txd[c*DW +: DW] = '0;
            snd[c] = 1'b0;
            pos[c] = 0;
            fl[c]--;
            if (fl[c] <= 0) ch_req[c] = 1'b0;
            len[c] = $urandom_range(1, 24);
            dly[c] = $urandom_range(0, 4);
          end
        end
      end else begin
        if (wasg[c] && nostart[c]) begin
          ch_req[c]  = 1'b0;
          fl[c]      = 0;
          nostart[c] = 1'b0;
        end
        wasg[c] = 1'b0;
        ch_tx_en[c] = 1'($urandom_range(0, 1));
        ch_txd[c*DW +: DW] = 8'hAA;
      end
    end
  endtask

  task automatic run_traffic(int budget);
    int n = 0;
    while (ch_req != '0 && n < budget) begin
      drive_cycle();
      n++;
    end
    chk("traffic_done", longint'(ch_req), 0);
    repeat (IFG + 3) drive_cycle();
  endtask

  task automatic check_log(string name, int n, int e0 = 0, int e1 = 0, int e2 = 0, int e3 = 0);
    int ex[4] = '{e0, e1, e2, e3};
    chk({name, "_count"}, longint'(gnt_log.size()), n);
    for (int i = 0; i < n && i < gnt_log.size(); i++) chk({name, "_order"}, gnt_log[i], ex[i]);
    gnt_log.delete();
  endtask

  task automatic clear_sources();
    ch_req   = '0;
    ch_tx_en = '0;
    ch_txd   = '0;
    for (int c = 0; c < N; c++) begin
      fl[c] = 0; len[c] = 0; pos[c] = 0; dly[c] = 0;
      snd[c] = 1'b0; nostart[c] = 1'b0; wasg[c] = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_sources();
    #1;
    chk("rst_gnt", longint'(ch_gnt), 0);
    chk("rst_en", longint'(gmii_tx_en), 0);
    chk("rst_txd", longint'(gmii_txd), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_to_err", longint'(to_err), 0);
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    drive_cycle();

    // Single UDP frame of 60 bytes
    queue_frames(CH_UDP, 1, 60, 0);
    run_traffic(200);
    check_log("single_udp", 1, CH_UDP);

    // ARP and UDP together: ARP first, UDP after the gap
    queue_frames(CH_ARP, 1, 42, 0);
    queue_frames(CH_UDP, 1, 20, 1);
    run_traffic(300);
    check_log("arp_first", 2, CH_ARP, CH_UDP);

    // ICMP frame moves the round-robin pointer back to 0
    queue_frames(CH_ICMP, 1, 8, 2);
    run_traffic(200);
    check_log("icmp_one", 1, CH_ICMP);

    // Continuous UDP/ICMP requests alternate
    queue_frames(CH_UDP, 2, 10, 0);
    queue_frames(CH_ICMP, 2, 10, 3);
    run_traffic(400);
    check_log("alternate", 4, CH_UDP, CH_ICMP, CH_UDP, CH_ICMP);

    // Start timeout: ICMP granted, never starts; UDP follows
    queue_frames(CH_UDP, 1, 5, 0);
    run_traffic(200);
    check_log("pre_to", 1, CH_UDP);
    nostart[CH_ICMP] = 1'b1;
    queue_frames(CH_ICMP, 1, 5, 0);
    queue_frames(CH_UDP, 1, 12, 0);
    run_traffic(300);
    check_log("timeout", 2, CH_ICMP, CH_UDP);

    // Randomised rounds
    for (int r = 0; r < 25; r++) begin
      int mask = $urandom_range(1, (1 << N) - 1);
      for (int c = 0; c < N; c++) begin
        if (mask[c]) begin
          queue_frames(c, $urandom_range(1, 3), $urandom_range(1, 24), $urandom_range(0, 4));
          if ($urandom_range(0, 7) == 0) begin
            nostart[c] = 1'b1;
            fl[c] = 1;
          end
        end
      end
      run_traffic(4000);
    end
    gnt_log.delete();

    // Reset in the middle of an ARP frame
    queue_frames(CH_ARP, 1, 30, 0);
    for (int n = 0; n < 40 && !gmii_tx_en; n++) drive_cycle();
    repeat (5) drive_cycle();
    chk("pre_rst_en", longint'(gmii_tx_en), 1);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_en", longint'(gmii_tx_en), 0);
    chk("mid_rst_gnt", longint'(ch_gnt), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    clear_sources();
    exp_q.delete();
    gnt_log.delete();
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    queue_frames(CH_ARP, 1, 10, 1);
    run_traffic(200);
    check_log("after_rst", 1, CH_ARP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
